// File: rtl/camera_timing_ctrl_if.sv
// Signal bundle between the host trigger logic / readout datapath and the
// camera timing controller. The controller connects through the slave
// modport; the trigger side uses the master modport.
// Optional feature macro: CAMERA_TIMING_PIXEL_EN adds the PIXEL test pattern.
interface camera_timing_ctrl_if #(
    parameter int CW = 7
);
    logic          START;
    logic          CONT;
    logic          ABORT;
    logic          BUSY;
    logic          FVAL;
    logic          LVAL;
    logic          FSYNC;
    logic          FRAME_DONE;
    logic [CW-1:0] COL;
    logic [CW-1:0] ROW;
`ifdef CAMERA_TIMING_PIXEL_EN
    logic [7:0]    PIXEL;
`endif

    modport master (
        output START, CONT, ABORT,
`ifdef CAMERA_TIMING_PIXEL_EN
        input  PIXEL,
`endif
        input  BUSY, FVAL, LVAL, FSYNC, FRAME_DONE, COL, ROW
    );

    modport slave (
        input  START, CONT, ABORT,
`ifdef CAMERA_TIMING_PIXEL_EN
        output PIXEL,
`endif
        output BUSY, FVAL, LVAL, FSYNC, FRAME_DONE, COL, ROW
    );
endinterface

// File: rtl/camera_timing_ctrl.sv
// Frame sequencer for the 64x64 dummy camera. Walks IDLE -> ACTIVE/HBLANK per
// line -> VBLANK per frame and produces frame/line valid, column/row indices,
// a frame-sync pulse on the first pixel and a frame-done pulse on the last
// vertical blanking cycle. Every output is a flop loaded from the next-state
// decode, so outputs line up with the state they describe.
// Optional feature macro: CAMERA_TIMING_PIXEL_EN adds a registered PIXEL
// pattern ((ROW<<2) ^ COL) during ACTIVE.
module camera_timing_ctrl #(
    parameter int COLS   = 64,
    parameter int ROWS   = 64,
    parameter int HBLANK = 8,
    parameter int VBLANK = 4,
    parameter int CW     = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    camera_timing_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(HBLANK - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VBLANK - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = CW'(0);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] blank_q, blank_d;
    logic          busy_q, busy_d;
    logic          fval_q, fval_d;
    logic          lval_q, lval_d;
    logic          fsync_q, fsync_d;
    logic          frame_done_q, frame_done_d;

`ifdef CAMERA_TIMING_PIXEL_EN
    logic [7:0]    pixel_q, pixel_d;

    // Test pattern for the dummy pixel source: low byte of (row<<2) ^ col.
    function automatic logic [7:0] pixel_pattern(input logic [CW-1:0] r,
                                                 input logic [CW-1:0] c);
        logic [31:0] mix;
        mix = (32'(r) << 2) ^ 32'(c);
        return mix[7:0];
    endfunction
`endif

    // Next-state, counter and output decode; ABORT overrides every state.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        blank_d = blank_q;
        fsync_d = 1'b0;

        if (bus.ABORT) begin
            state_d = ST_IDLE;
            col_d   = ZERO;
            row_d   = ZERO;
            blank_d = ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        state_d = ST_ACTIVE;
                        col_d   = ZERO;
                        row_d   = ZERO;
                        blank_d = ZERO;
                        fsync_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (col_q == COL_LAST) begin
                        state_d = ST_HBLANK;
                        col_d   = ZERO;
                        blank_d = ZERO;
                    end else begin
                        col_d   = col_q + ONE;
                    end
                end
                ST_HBLANK: begin
                    if (blank_q == H_LAST) begin
                        blank_d = ZERO;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_VBLANK;
                            row_d   = ZERO;
                        end else begin
                            state_d = ST_ACTIVE;
                            row_d   = row_q + ONE;
                            col_d   = ZERO;
                        end
                    end else begin
                        blank_d = blank_q + ONE;
                    end
                end
                ST_VBLANK: begin
                    if (blank_q == V_LAST) begin
                        blank_d = ZERO;
                        // Continuous mode is only looked at here, at frame end.
                        if (bus.CONT) begin
                            state_d = ST_ACTIVE;
                            col_d   = ZERO;
                            row_d   = ZERO;
                            fsync_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        blank_d = blank_q + ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    col_d   = ZERO;
                    row_d   = ZERO;
                    blank_d = ZERO;
                end
            endcase
        end

        busy_d       = (state_d != ST_IDLE);
        fval_d       = (state_d == ST_ACTIVE) || (state_d == ST_HBLANK);
        lval_d       = (state_d == ST_ACTIVE);
        frame_done_d = (state_d == ST_VBLANK) && (blank_d == V_LAST);

`ifdef CAMERA_TIMING_PIXEL_EN
        if (state_d == ST_ACTIVE) begin
            pixel_d = pixel_pattern(row_d, col_d);
        end else begin
            pixel_d = 8'd0;
        end
`endif
    end

    // State, counters and registered outputs; RST clears everything at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            col_q        <= ZERO;
            row_q        <= ZERO;
            blank_q      <= ZERO;
            busy_q       <= 1'b0;
            fval_q       <= 1'b0;
            lval_q       <= 1'b0;
            fsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CAMERA_TIMING_PIXEL_EN
            pixel_q      <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            blank_q      <= blank_d;
            busy_q       <= busy_d;
            fval_q       <= fval_d;
            lval_q       <= lval_d;
            fsync_q      <= fsync_d;
            frame_done_q <= frame_done_d;
`ifdef CAMERA_TIMING_PIXEL_EN
            pixel_q      <= pixel_d;
`endif
        end
    end

    // Column and row counters are zero outside their valid windows, so they
    // double as the COL/ROW outputs.
    assign bus.BUSY       = busy_q;
    assign bus.FVAL       = fval_q;
    assign bus.LVAL       = lval_q;
    assign bus.FSYNC      = fsync_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.COL        = col_q;
    assign bus.ROW        = row_q;
`ifdef CAMERA_TIMING_PIXEL_EN
    assign bus.PIXEL      = pixel_q;
`endif

endmodule

// File: tb/tb_camera_timing_ctrl.sv
// Directed bench for camera_timing_ctrl with default geometry
// (64x64, HBLANK 8, VBLANK 4 -> 72-cycle lines, 4612-cycle frames).
module tb_camera_timing_ctrl;

    localparam int CW     = 7;
    localparam int LINE   = 72;
    localparam int ACTIVE_END = 4608;
    localparam int PERIOD = 4612;

    logic CLK;
    logic RST;

    camera_timing_ctrl_if #(.CW(CW)) bus ();

    camera_timing_ctrl #(
        .COLS(64), .ROWS(64), .HBLANK(8), .VBLANK(4), .CW(CW)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_total;
    int n_bad;

    // Frame-scan statistics
    int n_fsync;
    int n_fd;
    int fd_k;
    int fsync_k;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " BUSY"},       32'(bus.BUSY),       32'd0);
        chk({tag, " FVAL"},       32'(bus.FVAL),       32'd0);
        chk({tag, " LVAL"},       32'(bus.LVAL),       32'd0);
        chk({tag, " FSYNC"},      32'(bus.FSYNC),      32'd0);
        chk({tag, " FRAME_DONE"}, 32'(bus.FRAME_DONE), 32'd0);
        chk({tag, " COL"},        32'(bus.COL),        32'd0);
        chk({tag, " ROW"},        32'(bus.ROW),        32'd0);
`ifdef CAMERA_TIMING_PIXEL_EN
        chk({tag, " PIXEL"},      32'(bus.PIXEL),      32'd0);
`endif
    endtask

    // Scan ncyc cycles starting at the first FSYNC cycle (k=0), comparing
    // against the line/frame timing computed from k. In continuous mode the
    // timing repeats every PERIOD cycles; otherwise the block is idle after.
    task automatic scan(input string nm, input int ncyc, input bit cont_mode,
                        input int start_k, input int cont_drop_k, input int cont_raise_k);
        int kk, pos, line, mis;
        bit e_busy, e_fval, e_lval, e_fsync, e_fd;
        int e_col, e_row;
        mis = 0; n_fsync = 0; n_fd = 0; fd_k = -1; fsync_k = -1;
        for (int k = 0; k < ncyc; k++) begin
            kk   = cont_mode ? (k % PERIOD) : k;
            pos  = kk % LINE;
            line = kk / LINE;
            e_busy  = cont_mode || (k < PERIOD);
            e_fval  = e_busy && (kk < ACTIVE_END);
            e_lval  = e_fval && (pos < 64);
            e_col   = e_lval ? pos : 0;
            e_row   = e_fval ? line : 0;
            e_fsync = e_busy && (kk == 0);
            e_fd    = e_busy && (kk == PERIOD - 1);
            if (bus.BUSY !== e_busy || bus.FVAL !== e_fval || bus.LVAL !== e_lval ||
                bus.FSYNC !== e_fsync || bus.FRAME_DONE !== e_fd ||
                int'(bus.COL) != e_col || int'(bus.ROW) != e_row)
                mis++;
            if (bus.FSYNC === 1'b1) begin n_fsync++; fsync_k = k; end
            if (bus.FRAME_DONE === 1'b1) begin n_fd++; fd_k = k; end
            if (k == 0) begin
                chk({nm, " k0 FSYNC"}, 32'(bus.FSYNC), 32'd1);
                chk({nm, " k0 LVAL"},  32'(bus.LVAL),  32'd1);
                chk({nm, " k0 COL"},   32'(bus.COL),   32'd0);
                chk({nm, " k0 ROW"},   32'(bus.ROW),   32'd0);
            end
            if (k == 63) chk({nm, " last pixel COL"}, 32'(bus.COL), 32'd63);
            if (k == 64) begin
                chk({nm, " hblank LVAL"}, 32'(bus.LVAL), 32'd0);
                chk({nm, " hblank FVAL"}, 32'(bus.FVAL), 32'd1);
            end
            if (k == 72) begin
                chk({nm, " line2 ROW"},   32'(bus.ROW),   32'd1);
                chk({nm, " line2 FSYNC"}, 32'(bus.FSYNC), 32'd0);
                chk({nm, " line2 LVAL"},  32'(bus.LVAL),  32'd1);
            end
            if (!cont_mode && k == PERIOD)
                chk({nm, " BUSY after done"}, 32'(bus.BUSY), 32'd0);
            if (cont_mode && k == PERIOD)
                chk({nm, " 2nd frame ROW"}, 32'(bus.ROW), 32'd0);
            bus.START = (k == start_k);
            if (k == cont_drop_k)  bus.CONT = 1'b0;
            if (k == cont_raise_k) bus.CONT = 1'b1;
            step();
        end
        bus.START = 1'b0;
        chk({nm, " cycles off model"}, 32'(mis), 32'd0);
    endtask

    initial begin
        int n_idle_fd;
        n_total = 0;
        n_bad   = 0;
        RST = 1'b1;
        bus.START = 1'b0;
        bus.CONT  = 1'b0;
        bus.ABORT = 1'b0;

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        RST = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk_all_zero("idle");

        // Frame 1, single shot, with a START pulse at ROW=5 COL=10 (ACTIVE)
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        scan("f1", PERIOD + 1, 1'b0, 5 * LINE + 10, -1, -1);
        chk("f1 FSYNC count",      32'(n_fsync), 32'd1);
        chk("f1 FRAME_DONE count", 32'(n_fd),    32'd1);
        chk("f1 FRAME_DONE cycle", 32'(fd_k),    32'(PERIOD - 1));

        // Continuous mode: CONT wobbles mid-frame, is high at frame end.
        bus.CONT  = 1'b1;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        scan("f2", PERIOD + 10 * LINE + 64 + 3, 1'b1, -1, 1000, 4500);
        chk("f2 FSYNC count",      32'(n_fsync), 32'd2);
        chk("f2 2nd FSYNC cycle",  32'(fsync_k), 32'(PERIOD));
        chk("f2 FRAME_DONE count", 32'(n_fd),    32'd1);
        chk("f2 FRAME_DONE cycle", 32'(fd_k),    32'(PERIOD - 1));

        // Now in HBLANK of ROW 10, blank count 3: abort.
        chk("pre-abort ROW",  32'(bus.ROW),  32'd10);
        chk("pre-abort LVAL", 32'(bus.LVAL), 32'd0);
        chk("pre-abort FVAL", 32'(bus.FVAL), 32'd1);
        bus.CONT  = 1'b0;
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        chk_all_zero("abort");
        n_idle_fd = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.FRAME_DONE !== 1'b0 || bus.BUSY !== 1'b0) n_idle_fd++;
            step();
        end
        chk("post-abort stays idle", 32'(n_idle_fd), 32'd0);

        // ABORT wins over START in IDLE
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        chk("abort+start BUSY",  32'(bus.BUSY),  32'd0);
        chk("abort+start FSYNC", 32'(bus.FSYNC), 32'd0);

        // Restart after abort
        step();
        bus.START = 1'b0;
        chk("restart FSYNC", 32'(bus.FSYNC), 32'd1);
        chk("restart ROW",   32'(bus.ROW),   32'd0);
        chk("restart COL",   32'(bus.COL),   32'd0);
        for (int k = 1; k <= LINE + 1; k++) begin
            step();
`ifdef CAMERA_TIMING_PIXEL_EN
            if (k == 3)  chk("pixel r0c3",    32'(bus.PIXEL), 32'd3);
            if (k == 66) chk("pixel hblank",  32'(bus.PIXEL), 32'd0);
`endif
        end
        chk("r1c1 ROW",  32'(bus.ROW),  32'd1);
        chk("r1c1 COL",  32'(bus.COL),  32'd1);
        chk("r1c1 LVAL", 32'(bus.LVAL), 32'd1);
`ifdef CAMERA_TIMING_PIXEL_EN
        chk("pixel r1c1", 32'(bus.PIXEL), 32'h05);
`endif

        // Asynchronous reset between clock edges during ACTIVE
        #2;
        RST = 1'b1;
        #1;
        chk_all_zero("async rst");
        #2;
        RST = 1'b0;
        step();
        step();
        chk_all_zero("after rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
